// File: rtl/rate_sequencer.sv
// Rate table sequencer feeding the PWM divider's rate input.
// Optional `RATE_SEQ_SKIP_EN: slots with a zero rate are skipped.
module rate_sequencer #(
  parameter int RATE_W    = 24,
  parameter int DWELL_W   = 24,
  parameter int DEF_RATE0 = 1388,
  parameter int DEF_RATE1 = 1249,
  parameter int DEF_RATE2 = 1332,
  parameter int DEF_RATE3 = 1388,
  parameter int DEF_DWELL = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [RATE_W-1:0]  rate,
  output logic [1:0]         slot,
  output logic               active,
  output logic               rate_update,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [RATE_W-1:0]  rate_tab  [4];
  logic [DWELL_W-1:0] dwell_tab [4];
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0]  rate_d;
  logic [1:0]         slot_d;
  logic               upd_d, done_d;
  logic [3:0]         en;
  logic               hi_found, lo_found;
  logic [1:0]         hi_idx, lo_idx;
  logic               enter;
  logic [1:0]         tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_tab[0] <= RATE_W'(DEF_RATE0);
      rate_tab[1] <= RATE_W'(DEF_RATE1);
      rate_tab[2] <= RATE_W'(DEF_RATE2);
      rate_tab[3] <= RATE_W'(DEF_RATE3);
      for (int i = 0; i < 4; i++)
        dwell_tab[i] <= DWELL_W'(DEF_DWELL);
    end else if (cfg_we) begin
      rate_tab[cfg_addr]  <= cfg_rate;
      dwell_tab[cfg_addr] <= cfg_dwell;
    end
  end

`ifdef RATE_SEQ_SKIP_EN
  always_comb begin
    en = '0;
    for (int i = 0; i < 4; i++)
      en[i] = (rate_tab[i] != '0);
  end
`else
  assign en = 4'hf;
`endif

  // hi: lowest enabled slot above the current one; lo: lowest overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 2'd0;
    lo_found = 1'b0;
    lo_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (i > int'(slot))) begin
        hi_found = 1'b1;
        hi_idx   = 2'(i);
      end
      if (en[i]) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rate_d  = rate;
    slot_d  = slot;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    enter   = 1'b0;
    tgt     = slot;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && lo_found) begin
          enter = 1'b1;
          tgt   = lo_idx;
        end
      end
      RUN: begin
        unique case (1'b1)
          stop: state_d = IDLE;
          (!stop && cnt_q != '0): cnt_d = cnt_q - 1'b1;
          (!stop && cnt_q == '0 && hi_found): begin
            enter = 1'b1;
            tgt   = hi_idx;
          end
          (!stop && cnt_q == '0 && !hi_found
            && loop_en && lo_found): begin
            enter = 1'b1;
            tgt   = lo_idx;
          end
          default: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (enter) begin
      state_d = RUN;
      slot_d  = tgt;
      rate_d  = rate_tab[tgt];
      cnt_d   = dwell_tab[tgt];
      upd_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rate        <= RATE_W'(DEF_RATE0);
      slot        <= 2'd0;
      cnt_q       <= '0;
      rate_update <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate        <= rate_d;
      slot        <= slot_d;
      cnt_q       <= cnt_d;
      rate_update <= upd_d;
      done        <= done_d;
    end
  end

  assign active = (state_q == RUN);

endmodule

// File: tb/tb_rate_sequencer.sv
// Scoreboard bench for rate_sequencer: expected slot entries and
// completions are queued by stimulus and checked by a monitor.
module tb_rate_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [23:0] cfg_rate = '0;
  logic [23:0] cfg_dwell = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [23:0] rate;
  logic [1:0]  slot;
  logic        active;
  logic        rate_update;
  logic        done;

  rate_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_rate(cfg_rate), .cfg_dwell(cfg_dwell),
    .start(start), .stop(stop), .loop_en(loop_en),
    .rate(rate), .slot(slot), .active(active),
    .rate_update(rate_update), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [1:0]  slot;
    logic [23:0] rate;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  b;

  always @(posedge clk) cyc++;

  // monitor: every slot entry or completion must match the queue head
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (rate_update || done)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d upd=%0b done=%0b slot=%0d rate=%0d",
                 cyc, rate_update, done, slot, rate);
      end else begin
        e = q.pop_front();
        if (e.is_done != done || e.is_done == rate_update ||
            e.cyc != cyc || e.slot !== slot || e.rate !== rate) begin
          n_bad++;
          $display("FAIL event got cyc=%0d done=%0b slot=%0d rate=%0d want cyc=%0d done=%0b slot=%0d rate=%0d",
                   cyc, done, slot, rate, e.cyc, e.is_done, e.slot, e.rate);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input bit d, input int c, input int s, input int r);
    ev_t e;
    e.is_done = d;
    e.cyc = c;
    e.slot = 2'(s);
    e.rate = 24'(r);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wr(input int a, input int r, input int d);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_rate = 24'(r);
    cfg_dwell = 24'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  // start sampled at the next edge; b = cycle of the first slot entry
  task automatic go();
    start = 1'b1;
    b = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic ex_pass(input int base);
    ex(0, base, 0, 100);
    ex(0, base + 4, 1, 200);
    ex(0, base + 6, 2, 300);
    ex(0, base + 7, 3, 400);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_rate", int'(rate), 1388);
      chk("rst_slot", int'(slot), 0);
      chk("rst_flags", {active, done, rate_update}, 0);
      tick();
    end

    wr(0, 100, 3);
    wr(1, 200, 1);
    wr(2, 300, 0);
    wr(3, 400, 2);

    // one-shot pass
    loop_en = 1'b0;
    b = cyc + 1;
    ex_pass(b);
    ex(1, b + 10, 3, 400);
    go();
    repeat (12) tick();
    chk("oneshot_rate", int'(rate), 400);
    chk("oneshot_active", int'(active), 0);

    // looping, start ignored while running, stop mid slot 0
    loop_en = 1'b1;
    b = cyc + 1;
    ex_pass(b);
    ex(0, b + 10, 0, 100);
    go();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < b + 12) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_active", int'(active), 0);
    chk("stop_rate", int'(rate), 100);
    chk("stop_slot", int'(slot), 0);
    repeat (4) tick();

    // start and stop together from idle
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    chk("startstop_active", int'(active), 0);

    // rewrite the active slot: takes effect at its next entry
    b = cyc + 1;
    ex_pass(b);
    ex(0, b + 10, 0, 100);
    ex(0, b + 14, 1, 555);
    go();
    repeat (4) tick();
    cfg_we = 1'b1;
    cfg_addr = 2'd1;
    cfg_rate = 24'd555;
    cfg_dwell = 24'd1;
    tick();
    cfg_we = 1'b0;
    chk("wr_hold_rate", int'(rate), 200);
    while (cyc < b + 14) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wr_new_rate", int'(rate), 555);
    chk("wr_slot", int'(slot), 1);
    wr(1, 200, 1);

    // done and start in the same cycle
    loop_en = 1'b0;
    b = cyc + 1;
    ex_pass(b);
    ex(1, b + 10, 3, 400);
    ex_pass(b + 11);
    ex(1, b + 21, 3, 400);
    go();
    repeat (10) tick();
    chk("done_pulse", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();

    // reset mid run: abort with no done, table reloads
    b = cyc + 1;
    ex(0, b, 0, 100);
    ex(0, b + 4, 1, 200);
    go();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rate", int'(rate), 1388);
    chk("midrst_slot", int'(slot), 0);
    chk("midrst_active", int'(active), 0);
    repeat (5) tick();

    wr(0, 100, 0);
    wr(1, 0, 0);
    wr(2, 0, 0);
    wr(3, 400, 0);
    b = cyc + 1;
`ifdef RATE_SEQ_SKIP_EN
    ex(0, b, 0, 100);
    ex(0, b + 1, 3, 400);
    ex(1, b + 2, 3, 400);
`else
    ex(0, b, 0, 100);
    ex(0, b + 1, 1, 0);
    ex(0, b + 2, 2, 0);
    ex(0, b + 3, 3, 400);
    ex(1, b + 4, 3, 400);
`endif
    go();
    repeat (6) tick();
`ifdef RATE_SEQ_SKIP_EN
    wr(0, 0, 0);
    wr(3, 0, 0);
    go();
    tick();
    chk("allzero_active", int'(active), 0);
    repeat (3) tick();
`endif

    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
